game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_pkg.sv | 18 +
 rtl/game_sequencer_if.sv | 28 ++
 rtl/bcd_inc2.sv | 28 ++
 rtl/game_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and widths for the game sequencer.
// State encodings, BCD digit width and score width live here.
package game_pkg;

    localparam int BCD_W   = 4;
    localparam int SCORE_W = 8;
    localparam int CNT_W   = 8;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'h99;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle of the sequencer's game-side strobes and status outputs.
// master drives the game events, slave is the sequencer side.
interface game_sequencer_if;
    import game_pkg::*;

    logic               frame;
    logic               flap;
    logic               collide;
    logic               pipe_pass;
    logic               obj_rst;
    logic               run;
    logic               flap_out;
    logic [1:0]         state;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] hiscore;
    logic               flash;

    modport master (
        output frame, flap, collide, pipe_pass,
        input  obj_rst, run, flap_out, state, score, hiscore, flash
    );

    modport slave (
        input  frame, flap, collide, pipe_pass,
        output obj_rst, run, flap_out, state, score, hiscore, flash
    );

endinterface

// File: rtl/bcd_inc2.sv
// Two-digit BCD increment, saturating at 99.
// Purely combinational.
module bcd_inc2
    import game_pkg::*;
(
    input  logic [SCORE_W-1:0] bcd_i,
    output logic [SCORE_W-1:0] bcd_o
);

    logic [BCD_W-1:0] lo;
    logic [BCD_W-1:0] hi;

    assign lo = bcd_i[BCD_W-1:0];
    assign hi = bcd_i[SCORE_W-1:BCD_W];

    // Carry the low digit into the high digit; hold at 99
    always_comb begin
        bcd_o = bcd_i;
        if (bcd_i != SCORE_MAX) begin
            if (lo == 4'd9) begin
                bcd_o = {hi + 4'd1, 4'd0};
            end else begin
                bcd_o = {hi, lo + 4'd1};
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game flow FSM: READY -> PLAY -> DYING -> OVER -> READY.
// Owns score, high score, death flash and flap gating.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned DEATH_FRAMES = 60,
    parameter int unsigned ARM_FRAMES   = 30,
    parameter int unsigned FLASH_SHIFT  = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frame,
    input  logic               i_flap,
    input  logic               i_collide,
    input  logic               i_pipe_pass,
    output logic               o_obj_rst,
    output logic               o_run,
    output logic               o_flap,
    output logic [1:0]         o_state,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_hiscore,
    output logic               o_flash
);

    localparam logic [CNT_W-1:0] DEATH_CNT  = CNT_W'(DEATH_FRAMES);
    localparam logic [CNT_W-1:0] ARM_CNT    = CNT_W'(ARM_FRAMES);
    localparam logic [CNT_W-1:0] FLASH_MASK = CNT_W'((1 << FLASH_SHIFT) - 1);

    logic [1:0]         rst_sync_q;
    logic               rst_n_s;
    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_d;
    logic [SCORE_W-1:0] hi_q;
    logic [SCORE_W-1:0] hi_d;
    logic [SCORE_W-1:0] score_inc;
    logic               flash_q;
    logic               flash_d;
    logic               flap_q;
    logic               flap_d;
    logic [CNT_W-1:0]   frame_idx;

    // Reset asserts at once, releases two clocks after i_rst_n rises
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_q[1];

    bcd_inc2 u_bcd_inc2 (
        .bcd_i (score_q),
        .bcd_o (score_inc)
    );

    // Frames already spent in DYING, 0 on the first death frame
    assign frame_idx = DEATH_CNT - cnt_q;

    // State register
    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q <= ST_READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_READY: if (i_flap)                    state_d = ST_PLAY;
            ST_PLAY:  if (i_collide)                 state_d = ST_DYING;
            ST_DYING: if (i_frame && cnt_q == 8'd1)  state_d = ST_OVER;
            ST_OVER:  if (i_flap && cnt_q == 8'd0)   state_d = ST_READY;
            default:                                 state_d = ST_READY;
        endcase
    end

    // Counter, score, flash and flap gating next values
    always_comb begin
        cnt_d   = cnt_q;
        score_d = score_q;
        hi_d    = hi_q;
        flash_d = 1'b0;
        flap_d  = 1'b0;
        unique case (state_q)
            ST_READY: begin
                cnt_d  = '0;
                flap_d = i_flap;
                if (i_flap) begin
                    score_d = '0;
                end
            end
            ST_PLAY: begin
                flap_d = i_flap;
                if (i_collide) begin
                    cnt_d = DEATH_CNT;
                end else if (i_pipe_pass) begin
                    score_d = score_inc;
                end
            end
            ST_DYING: begin
                flash_d = flash_q;
                if (i_frame) begin
                    if (cnt_q == 8'd1) begin
                        cnt_d   = ARM_CNT;
                        flash_d = 1'b0;
                        if (score_q > hi_q) begin
                            hi_d = score_q;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                        if ((frame_idx & FLASH_MASK) == '0) begin
                            flash_d = ~flash_q;
                        end
                    end
                end
            end
            ST_OVER: begin
                if (i_frame && cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            cnt_q   <= '0;
            score_q <= '0;
            hi_q    <= '0;
            flash_q <= 1'b0;
            flap_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            score_q <= score_d;
            hi_q    <= hi_d;
            flash_q <= flash_d;
            flap_q  <= flap_d;
        end
    end

    // Moore outputs decoded from the state register
    always_comb begin
        o_obj_rst = 1'b0;
        o_run     = 1'b0;
        o_state   = state_q;
        unique case (1'b1)
            state_q == ST_READY: o_obj_rst = 1'b1;
            state_q == ST_PLAY:  o_run     = 1'b1;
            default:             o_run     = 1'b0;
        endcase
    end

    assign o_flap    = flap_q;
    assign o_score   = score_q;
    assign o_hiscore = hi_q;
    assign o_flash   = flash_q;

endmodule
